// File: rtl/k12_alu_pkg.sv
// Shared constants for the K12 sequential ALU: op codes, condition selects, FSM and iterator encodings.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package k12_alu_pkg;

    // Operation codes
    localparam logic [3:0] OP_PASSA = 4'd0;
    localparam logic [3:0] OP_AND   = 4'd1;
    localparam logic [3:0] OP_OR    = 4'd2;
    localparam logic [3:0] OP_XOR   = 4'd3;
    localparam logic [3:0] OP_ADD   = 4'd4;
    localparam logic [3:0] OP_SUB   = 4'd5;
    localparam logic [3:0] OP_ADC   = 4'd6;
    localparam logic [3:0] OP_SBC   = 4'd7;
    localparam logic [3:0] OP_ASR1  = 4'd8;
    localparam logic [3:0] OP_PASSB = 4'd9;
    localparam logic [3:0] OP_SHL_N = 4'd10;
    localparam logic [3:0] OP_SHR_N = 4'd11;
    localparam logic [3:0] OP_ASR_N = 4'd12;
    localparam logic [3:0] OP_MUL   = 4'd13;

    // Condition selects
    localparam logic [2:0] CS_Z       = 3'd0;
    localparam logic [2:0] CS_N       = 3'd1;
    localparam logic [2:0] CS_BORROW  = 3'd2;
    localparam logic [2:0] CS_V       = 3'd3;
    localparam logic [2:0] CS_BORROW2 = 3'd4;
    localparam logic [2:0] CS_ULE     = 3'd5;
    localparam logic [2:0] CS_SLT     = 3'd6;
    localparam logic [2:0] CS_SLE     = 3'd7;

    // Top-level FSM encoding
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Iterative unit operation kind
    typedef enum logic [1:0] {
        IT_SHL = 2'd0,
        IT_SHR = 2'd1,
        IT_ASR = 2'd2,
        IT_MUL = 2'd3
    } iter_kind_t;

    // Ops that drive the adder result and load the carry register
    function automatic logic is_arith(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_ADC) || (op == OP_SBC);
    endfunction

endpackage

// File: rtl/k12_alu_iter.sv
// Iterative datapath: one-bit-per-cycle shifter and (optionally) shift-add unsigned multiplier.
// Latency: cnt_i cycles after start_i; last_o marks the cycle whose step_*_o is the final result.
// Backpressure: none; the owner only starts it when idle and must capture the result on last_o.
//
// Ports: clk/rst_n; start_i loads kind_i, cnt_i, opa_i (and opb_i); step_lo_o/step_hi_o are the
// combinational next-step values; last_o is high while the final step is being computed.
// Build option: K12_ALU_MUL_EN adds the multiplier (opb_i port, high-half and multiplicand registers).
module k12_alu_iter
    import k12_alu_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CW    = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  iter_kind_t       kind_i,
    input  logic [CW-1:0]    cnt_i,
    input  logic [WIDTH-1:0] opa_i,
`ifdef K12_ALU_MUL_EN
    input  logic [WIDTH-1:0] opb_i,
`endif
    output logic [WIDTH-1:0] step_lo_o,
    output logic [WIDTH-1:0] step_hi_o,
    output logic             last_o
);

    logic [CW-1:0]    count_q;
    iter_kind_t       kind_q;
    logic [WIDTH-1:0] lo_q;

`ifdef K12_ALU_MUL_EN
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH:0]   psum;
`endif

    always_comb begin
        step_lo_o = lo_q;
        step_hi_o = '0;
`ifdef K12_ALU_MUL_EN
        step_hi_o = hi_q;
        // Add the multiplicand when the current multiplier bit (lo_q[0]) is set,
        // then shift the {carry, hi, lo} product register right by one.
        psum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
`endif
        case (kind_q)
            IT_SHL: step_lo_o = {lo_q[WIDTH-2:0], 1'b0};
            IT_SHR: step_lo_o = {1'b0, lo_q[WIDTH-1:1]};
            IT_ASR: step_lo_o = {lo_q[WIDTH-1], lo_q[WIDTH-1:1]};
`ifdef K12_ALU_MUL_EN
            IT_MUL: {step_hi_o, step_lo_o} = {psum, lo_q[WIDTH-1:1]};
`endif
            default: ;
        endcase
    end

    assign last_o = (count_q == CW'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            kind_q  <= IT_SHL;
            lo_q    <= '0;
`ifdef K12_ALU_MUL_EN
            hi_q    <= '0;
            mcand_q <= '0;
`endif
        end else if (start_i) begin
            count_q <= cnt_i;
            kind_q  <= kind_i;
`ifdef K12_ALU_MUL_EN
            // For MUL the low half starts as the multiplier and is consumed LSB first.
            lo_q    <= (kind_i == IT_MUL) ? opb_i : opa_i;
            hi_q    <= '0;
            mcand_q <= opa_i;
`else
            lo_q    <= opa_i;
`endif
        end else if (count_q != '0) begin
            count_q <= count_q - CW'(1);
            lo_q    <= step_lo_o;
`ifdef K12_ALU_MUL_EN
            hi_q    <= step_hi_o;
`endif
        end
    end

endmodule

// File: rtl/k12_alu_seq.sv
// Registered K12 ALU with valid/ready handshake, persistent ADC/SBC carry and iterative shift/multiply.
// Latency: 1 cycle single-cycle ops and zero shifts, N+1 for shift by N, WIDTH+1 for MUL.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE (max 1 op / 2 cycles).
//
// Ports: clk, rst_n (async active-low); in_valid/in_ready with op, a, b, imm, use_imm, cond_sel,
// cond_inv sampled at accept; out_valid/out_ready with res, res_hi, cond; carry is the live carry reg.
// Build option: K12_ALU_MUL_EN enables op 13 (MUL); otherwise op 13 behaves as a reserved op.
module k12_alu_seq
    import k12_alu_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] imm,
    input  logic             use_imm,
    input  logic [2:0]       cond_sel,
    input  logic             cond_inv,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic [WIDTH-1:0] res_hi,
    output logic             cond,
    output logic             carry
);

    localparam int CW = SHW + 1;

`ifdef K12_ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    state_t           state_q, state_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] res_hi_q, res_hi_d;
    logic             cond_q, cond_d;
    logic             carry_q, carry_d;

    // Single-cycle datapath
    logic [WIDTH-1:0] b_eff;
    logic             add_mode;
    logic [WIDTH-1:0] addend;
    logic             cin;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             f_z, f_n, f_b, f_v, f_slt;
    logic             cond_pick;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] sc_res;
    logic             is_shift, is_mul, is_rsv, need_iter;

    // Iterative unit interface
    logic             iter_start;
    iter_kind_t       iter_kind;
    logic [CW-1:0]    iter_cnt;
    logic [WIDTH-1:0] step_lo, step_hi;
    logic             iter_last;

    always_comb begin
        b_eff    = use_imm ? imm : b;
        // Only ADD/ADC add; every other op runs a compare (A - B') so flags are always meaningful.
        add_mode = (op == OP_ADD) || (op == OP_ADC);
        addend   = add_mode ? b_eff : ~b_eff;
        if ((op == OP_ADC) || (op == OP_SBC)) begin
            cin = carry_q;
        end else begin
            cin = ~add_mode;
        end
        {cout, sum} = {1'b0, a} + {1'b0, addend} + {{WIDTH{1'b0}}, cin};

        f_z   = (sum == '0);
        f_n   = sum[WIDTH-1];
        f_b   = ~cout;
        // Overflow: both adder inputs share a sign that differs from the result's sign.
        f_v   = (a[WIDTH-1] == addend[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
        f_slt = f_n ^ f_v;

        case (cond_sel)
            CS_Z:       cond_pick = f_z;
            CS_N:       cond_pick = f_n;
            CS_BORROW:  cond_pick = f_b;
            CS_V:       cond_pick = f_v;
            CS_BORROW2: cond_pick = f_b;
            CS_ULE:     cond_pick = f_z | f_b;
            CS_SLT:     cond_pick = f_slt;
            CS_SLE:     cond_pick = f_z | f_slt;
            default:    cond_pick = 1'b0;
        endcase

        shamt     = b_eff[SHW-1:0];
        is_shift  = (op == OP_SHL_N) || (op == OP_SHR_N) || (op == OP_ASR_N);
        is_mul    = (op == OP_MUL) && MUL_EN;
        is_rsv    = (op == 4'd14) || (op == 4'd15) || ((op == OP_MUL) && !MUL_EN);
        need_iter = (is_shift && (shamt != '0)) || is_mul;

        // Zero-amount shifts, reserved ops and disabled MUL all fall to the default (pass A).
        case (op)
            OP_AND:   sc_res = a & b_eff;
            OP_OR:    sc_res = a | b_eff;
            OP_XOR:   sc_res = a ^ b_eff;
            OP_ADD,
            OP_SUB,
            OP_ADC,
            OP_SBC:   sc_res = sum;
            OP_ASR1:  sc_res = {a[WIDTH-1], a[WIDTH-1:1]};
            OP_PASSB: sc_res = b_eff;
            default:  sc_res = a;
        endcase

        case (op)
            OP_SHL_N: iter_kind = IT_SHL;
            OP_SHR_N: iter_kind = IT_SHR;
            OP_ASR_N: iter_kind = IT_ASR;
            default:  iter_kind = IT_MUL;
        endcase
        iter_cnt = is_mul ? CW'(WIDTH) : {1'b0, shamt};
    end

    // Next-state and output-register logic
    always_comb begin
        state_d    = state_q;
        res_d      = res_q;
        res_hi_d   = res_hi_q;
        cond_d     = cond_q;
        carry_d    = carry_q;
        iter_start = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    cond_d = is_rsv ? 1'b0 : (cond_pick ^ cond_inv);
                    if (is_arith(op)) begin
                        carry_d = cout;
                    end
                    if (need_iter) begin
                        iter_start = 1'b1;
                        state_d    = ST_BUSY;
                    end else begin
                        res_d    = sc_res;
                        res_hi_d = '0;
                        state_d  = ST_DONE;
                    end
                end
            end
            ST_BUSY: begin
                // Capture the final step directly from the iterator's next-value outputs.
                if (iter_last) begin
                    res_d    = step_lo;
                    res_hi_d = step_hi;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            res_q    <= '0;
            res_hi_q <= '0;
            cond_q   <= 1'b0;
            carry_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            res_q    <= res_d;
            res_hi_q <= res_hi_d;
            cond_q   <= cond_d;
            carry_q  <= carry_d;
        end
    end

    k12_alu_iter #(
        .WIDTH (WIDTH)
    ) u_iter (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (iter_start),
        .kind_i    (iter_kind),
        .cnt_i     (iter_cnt),
        .opa_i     (a),
`ifdef K12_ALU_MUL_EN
        .opb_i     (b_eff),
`endif
        .step_lo_o (step_lo),
        .step_hi_o (step_hi),
        .last_o    (iter_last)
    );

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign res       = res_q;
    assign res_hi    = res_hi_q;
    assign cond      = cond_q;
    assign carry     = carry_q;

endmodule

// File: tb/tb_k12_alu_seq.sv
// Scoreboard bench for k12_alu_seq: directed cases plus random ops against an arithmetic model.
// Latency: n/a.
// Backpressure: the monitor drives out_ready randomly, with forced holds on request.
module tb_k12_alu_seq;

    localparam int     W    = 8;
    localparam longint FULL = 256;
    localparam longint HALF = 128;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [3:0]   op = '0;
    logic [W-1:0] a = '0, b = '0, imm = '0;
    logic         use_imm = 1'b0;
    logic [2:0]   cond_sel = '0;
    logic         cond_inv = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] res, res_hi;
    logic         cond, carry;

    k12_alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .imm(imm), .use_imm(use_imm),
        .cond_sel(cond_sel), .cond_inv(cond_inv),
        .out_valid(out_valid), .out_ready(out_ready),
        .res(res), .res_hi(res_hi), .cond(cond), .carry(carry)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint res;
        longint hi;
        bit     cond;
        bit     carry;
        int     lat;
        int     acc;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   hold_cnt = 0;
    bit   mc       = 1'b0;   // model carry register

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic longint sx(input longint v);
        return (v >= HALF) ? v - FULL : v;
    endfunction

    // Reference behaviour in plain integer arithmetic.
    function automatic exp_t model(input int o, input longint ta, input longint bp,
                                   input int cs, input bit ci, input bit cy);
        exp_t   e;
        bit     add, cout, z, n, v, bor, sel;
        longint opnd, cin, s, sm, st, p;
        int     sh;
        add  = (o == 4) || (o == 6);
        opnd = add ? bp : (FULL - 1 - bp);
        cin  = ((o == 6) || (o == 7)) ? longint'(cy) : (add ? 0 : 1);
        s    = ta + opnd + cin;
        sm   = s % FULL;
        cout = (s >= FULL);
        st   = sx(ta) + sx(opnd) + cin;
        v    = (st >= HALF) || (st < -HALF);
        z    = (sm == 0);
        n    = (sm >= HALF);
        bor  = !cout;
        case (cs)
            0: sel = z;
            1: sel = n;
            2: sel = bor;
            3: sel = v;
            4: sel = bor;
            5: sel = z | bor;
            6: sel = n ^ v;
            default: sel = z | (n ^ v);
        endcase
        sh     = int'(bp % W);
        e.res  = ta;
        e.hi   = 0;
        e.lat  = 1;
        e.cond = sel ^ ci;
        e.acc  = 0;
        case (o)
            0: e.res = ta;
            1: e.res = ta & bp;
            2: e.res = ta | bp;
            3: e.res = ta ^ bp;
            4, 5, 6, 7: e.res = sm;
            8: e.res = (ta >> 1) | (ta & HALF);
            9: e.res = bp;
            10: begin e.res = (ta << sh) % FULL; e.lat = sh + 1; end
            11: begin e.res = ta >> sh; e.lat = sh + 1; end
            12: begin e.res = (sx(ta) >>> sh) & (FULL - 1); e.lat = sh + 1; end
`ifdef K12_ALU_MUL_EN
            13: begin p = ta * bp; e.res = p % FULL; e.hi = p / FULL; e.lat = W + 1; end
`else
            13: begin p = 0; e.res = ta + p; e.cond = 1'b0; end
`endif
            default: begin e.res = ta; e.cond = 1'b0; end
        endcase
        e.carry = ((o >= 4) && (o <= 7)) ? cout : cy;
        return e;
    endfunction

    // Present one operation; returns at the negedge following its accept.
    task automatic issue(input int o, input logic [W-1:0] ta, input logic [W-1:0] tb,
                         input logic [W-1:0] ti, input bit tu, input int cs, input bit ci);
        int   waited;
        exp_t e;
        waited   = 0;
        op       = 4'(o);
        a        = ta;
        b        = tb;
        imm      = ti;
        use_imm  = tu;
        cond_sel = 3'(cs);
        cond_inv = ci;
        in_valid = 1'b1;
        while (!in_ready && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 64'(in_ready), 64'd1);
            in_valid = 1'b0;
        end else begin
            e     = model(o, longint'(ta), longint'(tu ? ti : tb), cs, ci, mc);
            e.acc = cyc + 1;
            mc    = e.carry;
            sb.push_back(e);
            @(negedge clk);
            // Scramble the operand buses while busy; they must be ignored.
            in_valid = 1'b0;
            op       = 4'($urandom);
            a        = W'($urandom);
            b        = W'($urandom);
            imm      = W'($urandom);
            cond_sel = 3'($urandom);
        end
    endtask

    // Monitor: checks latency, hold stability and, at each handshake, the scoreboard head.
    initial begin
        exp_t         e;
        bit           prev_v, rdy;
        logic [W-1:0] snap_res, snap_hi;
        logic         snap_cond;
        prev_v = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_v    = 1'b0;
                out_ready = 1'b0;
            end else if (out_valid) begin
                chk("in_ready_while_done", 64'(in_ready), 64'd0);
                if (!prev_v) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_result", 64'(out_valid), 64'd0);
                    end else begin
                        chk("latency", 64'(cyc - sb[0].acc + 1), 64'(sb[0].lat));
                    end
                    snap_res  = res;
                    snap_hi   = res_hi;
                    snap_cond = cond;
                end else begin
                    chk("hold_res", 64'(res), 64'(snap_res));
                    chk("hold_res_hi", 64'(res_hi), 64'(snap_hi));
                    chk("hold_cond", 64'(cond), 64'(snap_cond));
                end
                if (hold_cnt > 0) begin
                    hold_cnt--;
                    rdy = 1'b0;
                end else begin
                    rdy = ($urandom_range(0, 3) != 0);
                end
                if (rdy && sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("res", 64'(res), 64'(e.res));
                    chk("res_hi", 64'(res_hi), 64'(e.hi));
                    chk("cond", 64'(cond), 64'(e.cond));
                    chk("carry", 64'(carry), 64'(e.carry));
                end
                prev_v    = !rdy;
                out_ready = rdy;
            end else begin
                prev_v    = 1'b0;
                out_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    initial begin
        #1_000_000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_res", 64'(res), 64'd0);
        chk("rst_res_hi", 64'(res_hi), 64'd0);
        chk("rst_cond", 64'(cond), 64'd0);
        chk("rst_carry", 64'(carry), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases: overflow, compare flags, carry chain, shifts, multiply, reserved ops.
        issue(4,  8'h7F, 8'h01, 8'h00, 1'b0, 3, 1'b0);
        issue(5,  8'h10, 8'h00, 8'h20, 1'b1, 6, 1'b0);
        issue(5,  8'h10, 8'h00, 8'h20, 1'b1, 2, 1'b0);
        issue(4,  8'hFF, 8'h01, 8'h00, 1'b0, 0, 1'b0);
        issue(6,  8'h00, 8'h00, 8'h00, 1'b0, 0, 1'b0);
        issue(10, 8'h81, 8'h00, 8'h03, 1'b1, 0, 1'b0);
        issue(12, 8'h80, 8'h02, 8'h00, 1'b0, 1, 1'b0);
        issue(11, 8'hA5, 8'h00, 8'h00, 1'b0, 0, 1'b0);
        issue(11, 8'hA5, 8'hF8, 8'h00, 1'b0, 0, 1'b1);
        issue(12, 8'h9C, 8'h07, 8'h00, 1'b0, 7, 1'b0);
        issue(13, 8'h0F, 8'h11, 8'h00, 1'b0, 0, 1'b0);
        issue(13, 8'hFF, 8'h00, 8'hFF, 1'b1, 5, 1'b1);
        issue(14, 8'h3C, 8'h3C, 8'h00, 1'b0, 0, 1'b1);
        issue(15, 8'h5A, 8'h01, 8'h00, 1'b0, 7, 1'b1);
        issue(8,  8'h81, 8'h00, 8'h00, 1'b0, 1, 1'b0);
        issue(9,  8'h00, 8'h12, 8'h34, 1'b1, 0, 1'b0);
        hold_cnt = 5;
        issue(7,  8'h05, 8'h09, 8'h00, 1'b0, 5, 1'b0);

        // Reset in the middle of a long shift, with the carry register set beforehand.
        issue(4,  8'hFF, 8'h01, 8'h00, 1'b0, 0, 1'b0);
        issue(10, 8'h01, 8'h07, 8'h00, 1'b0, 0, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midbusy_rst_out_valid", 64'(out_valid), 64'd0);
        chk("midbusy_rst_res", 64'(res), 64'd0);
        chk("midbusy_rst_carry", 64'(carry), 64'd0);
        chk("midbusy_rst_in_ready", 64'(in_ready), 64'd1);
        sb.delete();
        mc = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);
        issue(6, 8'h01, 8'h01, 8'h00, 1'b0, 0, 1'b0);

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            issue(int'($urandom_range(0, 15)), W'($urandom), W'($urandom), W'($urandom),
                  1'($urandom), int'($urandom_range(0, 7)), 1'($urandom));
        end

        w = 0;
        while (sb.size() != 0 && w < 500) begin
            @(negedge clk);
            w++;
        end
        chk("drain_pending", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
